// File: rtl/adc_frame_capture.sv
// ADC frame capture: shifts ADC samples into a FRAME_LEN-deep history and
// emits whole frames (optionally 50 % overlapped) over a valid/ready output
// slot. Frames that find the slot occupied are dropped and counted.
module adc_frame_capture #(
  parameter int unsigned SAMPLE_W  = 4,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          overlap_en,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          sample_valid,
  output logic [FRAME_LEN*SAMPLE_W-1:0] frame_data,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [7:0]                    frame_index,
  output logic [7:0]                    drop_count,
  output logic                          busy
);

  localparam int unsigned DW = FRAME_LEN * SAMPLE_W;
  localparam int unsigned CW = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM
  } state_t;

  state_t        state;
  logic          mode_ovl;
  logic [DW-1:0] hist;
  logic [DW-1:0] hist_next;
  logic [CW-1:0] fill_cnt;
  logic [CW-1:0] hop_cnt;
  logic [CW-1:0] hop_last;
  logic [7:0]    seq;
  logic          take;
  logic          produce;
  logic          slot_free;

  // Next history, sample acceptance and frame-completion decode
  always_comb begin
    hist_next = {sample_in, hist[DW-1:SAMPLE_W]};
    hop_last  = mode_ovl ? CW'(FRAME_LEN / 2 - 1) : CW'(FRAME_LEN - 1);
    take      = sample_valid && enable && (state != IDLE);
    produce   = 1'b0;
    if (take) begin
      if (state == PRIME)
        produce = (fill_cnt == CW'(FRAME_LEN - 1));
      else if (state == STREAM)
        produce = (hop_cnt == hop_last);
    end
    slot_free = !frame_valid || frame_ready;
  end

  // Capture FSM, history shift register and output slot
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mode_ovl    <= 1'b0;
      hist        <= '0;
      fill_cnt    <= '0;
      hop_cnt     <= '0;
      seq         <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_index <= '0;
      drop_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          fill_cnt <= '0;
          hop_cnt  <= '0;
          if (enable) begin
            state    <= PRIME;
            mode_ovl <= overlap_en;
          end
        end
        PRIME: begin
          if (!enable) begin
            state    <= IDLE;
            fill_cnt <= '0;
            hop_cnt  <= '0;
          end else if (take) begin
            hist <= hist_next;
            if (fill_cnt == CW'(FRAME_LEN - 1)) begin
              state    <= STREAM;
              fill_cnt <= '0;
              hop_cnt  <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        STREAM: begin
          if (!enable) begin
            state    <= IDLE;
            fill_cnt <= '0;
            hop_cnt  <= '0;
          end else if (take) begin
            hist <= hist_next;
            if (hop_cnt == hop_last) hop_cnt <= '0;
            else                     hop_cnt <= hop_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A handshake and a new frame in the same cycle reuse the slot, so
      // frame_valid stays high; otherwise a handshake empties it.
      if (produce) begin
        if (slot_free) begin
          frame_data  <= hist_next;
          frame_valid <= 1'b1;
          frame_index <= seq;
          seq         <= seq + 8'd1;
        end else if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/adc_frame_capture.md
ADC_FRAME_CAPTURE -- requirements
Module: adc_frame_capture

Interface
REQ-001 The block SHALL have parameter SAMPLE_W, default 4: ADC sample width in bits (1..16).
REQ-002 The block SHALL have parameter FRAME_LEN, default 8: samples per frame, power of 2, 4..32.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port enable, input, 1: capture enable.
REQ-007 Port overlap_en, input, 1: 0 = hop FRAME_LEN (no overlap); 1 = hop FRAME_LEN/2 (50 % overlap).
REQ-008 Port sample_in, input, SAMPLE_W: unsigned ADC sample.
REQ-009 Port sample_valid, input, 1: one-cycle strobe qualifying sample_in.
REQ-010 Port frame_data, output, FRAME_LEN*SAMPLE_W: registered frame; slot k at bits [k*SAMPLE_W +: SAMPLE_W], slot 0 = oldest sample.
REQ-011 Port frame_valid, output, 1: frame_data holds an unaccepted frame.
REQ-012 Port frame_ready, input, 1: downstream (FFT) accepts frame; transfer when frame_valid && frame_ready.
REQ-013 Port frame_index, output, 8: sequence number of frame on frame_data.
REQ-014 Port drop_count, output, 8: frames discarded for lack of output space.
REQ-015 Port busy, output, 1: high in PRIME or STREAM.

Function
REQ-016 State machine SHALL have states IDLE, PRIME, STREAM.
REQ-017 IDLE -> PRIME when enable=1; overlap_en latched on this transition only and held until return to IDLE.
REQ-018 PRIME: each sample_valid shifts sample_in into an internal FRAME_LEN-deep history (newest at slot FRAME_LEN-1); after FRAME_LEN accepted samples -> STREAM and a frame is produced.
REQ-019 STREAM: each sample_valid shifts history and increments hop counter; when counter reaches hop size (per latched mode) a frame is produced and counter clears.
REQ-020 Any state -> IDLE when enable=0; history fill count and hop counter clear; frame_data/frame_valid/frame_index/drop_count retained.
REQ-021 sample_valid in IDLE SHALL be ignored.
REQ-022 Produced frame = history including the sample arriving in the completing cycle; frame_valid asserts the cycle after that sample's clk edge (latency 1).
REQ-023 Output slot free when frame_valid=0 or frame_ready=1 in the same cycle; if free, frame_data loads, frame_valid=1, frame_index increments (modulo 256, first frame after reset = 0).
REQ-024 If slot not free, the new frame is dropped, frame_data unchanged, drop_count increments saturating at 255.
REQ-025 frame_valid deasserts after handshake unless a new frame loads in that cycle; frame_data SHALL be stable while frame_valid=1 and frame_ready=0.
REQ-026 frame_ready while frame_valid=0 SHALL have no effect.
REQ-027 Samples stored unmodified; no arithmetic on sample values.
REQ-028 busy = (state != IDLE).

Reset
REQ-029 On rst=1 at a clk edge: state IDLE, history cleared to 0, counters 0, frame_data 0, frame_valid 0, frame_index 0, drop_count 0, busy 0; rst overrides all other inputs including in-progress capture and pending handshake.

Verification (SAMPLE_W=4, FRAME_LEN=8)
REQ-030 Non-overlap: enable=1, overlap_en=0, samples 1..8 with frame_ready=1 -> one cycle after sample 8, frame_valid=1, slots 0..7 = 1..8, frame_index=0; samples 9..16 -> second frame 9..16, frame_index=1.
REQ-031 Overlap: overlap_en=1, samples 1..12 -> frames {1..8} after sample 8 and {5..12} after sample 12, indices 0 and 1.
REQ-032 Backpressure: frame_ready=0, non-overlap, samples 1..24 -> frame_data stays {1..8}, frame_valid=1, drop_count=2; then frame_ready=1 one cycle -> frame_valid=0.
REQ-033 Simultaneous: frame_valid=1 with frame_ready=1 on the cycle the next frame completes -> new frame loads, frame_valid stays 1, drop_count unchanged.
REQ-034 Mid-operation: after 5 samples drop enable for 1 cycle then re-enable, feed 8 samples 20..27 -> frame {20..27}; separately rst after 5 samples -> all outputs 0, no frame until 8 further samples.
REQ-035 Saturation: 300 dropped frames -> drop_count=255 and holds.
